// File: rtl/controle_cifra.sv
// Iterative AES-128 encryption sequencer: one round per clock, key expanded on the fly.
// Optional block counter output is enabled by defining CONTA_BLOCOS_EN.
module controle_cifra #(
    parameter int NUM_RODADAS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         entrada_valida,
    output logic         entrada_pronta,
    input  logic [127:0] bloco,
    input  logic [127:0] chave,
    output logic         saida_valida,
    input  logic         saida_pronta,
    output logic [127:0] saida,
    output logic         ocupado,
    output logic [3:0]   rodada
`ifdef CONTA_BLOCOS_EN
    ,
    output logic [15:0]  blocos_cifrados
`endif
);

    typedef enum logic [1:0] {
        OCIOSO,
        RODANDO,
        CONCLUIDO
    } estado_t;

    localparam logic [3:0] ULTIMA = 4'(NUM_RODADAS);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the AES affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240, inv;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x12  = gmul(gmul(x3, x3), gmul(x3, x3));
        x15  = gmul(x12, x3);
        x240 = gmul(x15, x15);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        inv  = gmul(gmul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[i*8 +: 8] = sbox(s[i*8 +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] multiplica_colunas(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] expande(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w3, t, n0, n1, n2, n3;
        w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        t  = t ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    estado_t      r_est;
    estado_t      w_prox;
    logic [127:0] r_estado;
    logic [127:0] r_chave_rodada;
    logic [127:0] r_saida;
    logic         r_saida_valida;
    logic [3:0]   r_rodada;

    logic [127:0] w_k;
    logic [127:0] w_sr;
    logic [127:0] w_novo;
    logic         w_ultima;
    logic         w_aceita;
    logic         w_entrega;

    assign w_k       = expande(r_chave_rodada, rcon(r_rodada));
    assign w_sr      = shift_rows(sub_bytes(r_estado));
    assign w_ultima  = (r_rodada == ULTIMA);
    assign w_novo    = (w_ultima ? w_sr : multiplica_colunas(w_sr)) ^ w_k;
    assign w_aceita  = entrada_valida && (r_est == OCIOSO);
    assign w_entrega = r_saida_valida && saida_pronta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_est <= OCIOSO;
        else        r_est <= w_prox;
    end

    always_comb begin
        w_prox = r_est;
        unique case (r_est)
            OCIOSO:    if (w_aceita)  w_prox = RODANDO;
            RODANDO:   if (w_ultima)  w_prox = CONCLUIDO;
            CONCLUIDO: if (w_entrega) w_prox = OCIOSO;
            default:   w_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado       <= '0;
            r_chave_rodada <= '0;
            r_saida        <= '0;
            r_saida_valida <= 1'b0;
            r_rodada       <= 4'd0;
        end else begin
            case (r_est)
                OCIOSO: begin
                    if (w_aceita) begin
                        r_estado       <= bloco ^ chave;
                        r_chave_rodada <= chave;
                        r_rodada       <= 4'd1;
                    end
                end
                RODANDO: begin
                    r_estado       <= w_novo;
                    r_chave_rodada <= w_k;
                    if (w_ultima) begin
                        r_rodada       <= 4'd0;
                        r_saida        <= w_novo;
                        r_saida_valida <= 1'b1;
                    end else begin
                        r_rodada <= r_rodada + 4'd1;
                    end
                end
                CONCLUIDO: begin
                    if (w_entrega) r_saida_valida <= 1'b0;
                end
                default: r_saida_valida <= 1'b0;
            endcase
        end
    end

`ifdef CONTA_BLOCOS_EN
    logic [15:0] r_blocos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_blocos <= 16'd0;
        else if (w_entrega) r_blocos <= r_blocos + 16'd1;
    end

    assign blocos_cifrados = r_blocos;
`endif

    assign entrada_pronta = (r_est == OCIOSO);
    assign ocupado        = (r_est != OCIOSO);
    assign saida_valida   = r_saida_valida;
    assign saida          = r_saida;
    assign rodada         = r_rodada;

endmodule

// File: tb/tb_controle_cifra.sv
// Self-checking bench for controle_cifra: known-answer vectors, scoreboard,
// handshake timing, round trace and asynchronous reset.
module tb_controle_cifra;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         entrada_valida = 1'b0;
    logic         entrada_pronta;
    logic [127:0] bloco = '0;
    logic [127:0] chave = '0;
    logic         saida_valida;
    logic         saida_pronta = 1'b1;
    logic [127:0] saida;
    logic         ocupado;
    logic [3:0]   rodada;
`ifdef CONTA_BLOCOS_EN
    logic [15:0]  blocos_cifrados;
`endif

    always #5 clk = ~clk;

    controle_cifra dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .entrada_valida (entrada_valida),
        .entrada_pronta (entrada_pronta),
        .bloco          (bloco),
        .chave          (chave),
        .saida_valida   (saida_valida),
        .saida_pronta   (saida_pronta),
        .saida          (saida),
        .ocupado        (ocupado),
        .rodada         (rodada)
`ifdef CONTA_BLOCOS_EN
        ,
        .blocos_cifrados(blocos_cifrados)
`endif
    );

    typedef struct {
        logic [127:0] k;
        logic [127:0] p;
        logic [127:0] c;
        int           atraso;
    } vet_t;

    vet_t         tab[4];
    int           checks = 0;
    int           errors = 0;
    logic [127:0] q[$];
    logic [127:0] exp_in = '0;
    int           cyc = 0;
    int           n_acc = 0;
    int           n_hs = 0;
    int           t_acc = 0;
    int           t_acc_prev = 0;
    int           t_hs = 0;
    logic         hs_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nome, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nome, got, exp);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on output handshake
    always @(negedge clk) begin
        if (hs_prev) chk("valid_one_cycle", 128'(saida_valida), 128'd0);
        hs_prev = 1'b0;
        if (rst_n && entrada_valida && entrada_pronta) begin
            q.push_back(exp_in);
            t_acc_prev = t_acc;
            t_acc = cyc;
            n_acc++;
        end
        if (rst_n && saida_valida && saida_pronta) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output got %h", saida);
            end else begin
                chk("saida", saida, q.pop_front());
            end
            t_hs = cyc;
            n_hs++;
            hs_prev = 1'b1;
        end
    end

    task automatic envia(input int i, input bit manter);
        int n0;
        int c;
        n0 = n_acc;
        bloco = tab[i].p;
        chave = tab[i].k;
        exp_in = tab[i].c;
        entrada_valida = 1'b1;
        c = 0;
        while (n_acc == n0 && c < 100) begin
            @(posedge clk);
            c++;
        end
        if (n_acc == n0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got 0 expected 1");
        end
        #1;
        if (!manter) begin
            entrada_valida = 1'b0;
            bloco = {$urandom, $urandom, $urandom, $urandom};
            chave = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic espera_vazio(input int max);
        int c;
        c = 0;
        while (q.size() != 0 && c < max) begin
            @(posedge clk);
            c++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL output_timeout got %0d pending expected 0", q.size());
            q.delete();
        end
        #1;
    endtask

    task automatic espera_valida();
        int c;
        c = 0;
        while (!saida_valida && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("valid_wait", 128'(saida_valida), 128'd1);
    endtask

    task automatic roda(input int i);
        saida_pronta = (tab[i].atraso == 0);
        envia(i, 1'b0);
        if (tab[i].atraso > 0) begin
            espera_valida();
            repeat (tab[i].atraso) @(negedge clk);
            @(posedge clk);
            #1;
            saida_pronta = 1'b1;
        end
        espera_vazio(60);
    endtask

    initial begin
        tab[0] = '{128'h000102030405060708090a0b0c0d0e0f,
                   128'h00112233445566778899aabbccddeeff,
                   128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0};
        tab[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                   128'h3243f6a8885a308d313198a2e0370734,
                   128'h3925841d02dc09fbdc118597196a0b32, 3};
        tab[2] = '{128'h00000000000000000000000000000000,
                   128'h00000000000000000000000000000000,
                   128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 1};
        tab[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                   128'h6bc1bee22e409f96e93d7e117393172a,
                   128'h3ad77bb40d7a3660a89ecaf32466ef97, 0};

        #12;
        chk("rst_saida", saida, 128'd0);
        chk("rst_valida", 128'(saida_valida), 128'd0);
        chk("rst_ocupado", 128'(ocupado), 128'd0);
        chk("rst_rodada", 128'(rodada), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("pronta_after_rst", 128'(entrada_pronta), 128'd1);

        // Vector 1 with round trace, occupancy and latency
        saida_pronta = 1'b1;
        envia(0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("rodada_%0d", k), 128'(rodada), 128'(k));
            chk("ocupado_run", 128'(ocupado), 128'd1);
            chk("pronta_run", 128'(entrada_pronta), 128'd0);
        end
        @(negedge clk);
        chk("rodada_done", 128'(rodada), 128'd0);
        chk("valida_done", 128'(saida_valida), 128'd1);
        chk("ocupado_done", 128'(ocupado), 128'd1);
        #1;
        espera_vazio(20);
        chk("latencia", 128'(t_hs - t_acc), 128'd11);
        @(negedge clk);
        chk("ocupado_idle", 128'(ocupado), 128'd0);
        chk("pronta_idle", 128'(entrada_pronta), 128'd1);

        // Vector 2 with output back-pressure
        @(posedge clk);
        #1;
        saida_pronta = 1'b0;
        envia(1, 1'b0);
        espera_valida();
        for (int i = 0; i < 5; i++) begin
            chk("hold_saida", saida, tab[1].c);
            chk("hold_valida", 128'(saida_valida), 128'd1);
            chk("hold_pronta", 128'(entrada_pronta), 128'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        saida_pronta = 1'b1;
        espera_vazio(10);

        // Back-to-back accepts with input changing during the rounds
        envia(0, 1'b1);
        envia(1, 1'b0);
        chk("spacing", 128'(t_acc - t_acc_prev), 128'd12);
        espera_vazio(40);

        // Table-driven vectors with varying sink stalls
        for (int i = 0; i < 4; i++) begin
            roda(i);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of round 5
        envia(3, 1'b0);
        begin
            int c;
            c = 0;
            while (rodada != 4'd5 && c < 20) begin
                @(negedge clk);
                c++;
            end
        end
        chk("rodada_5", 128'(rodada), 128'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_saida", saida, 128'd0);
        chk("arst_valida", 128'(saida_valida), 128'd0);
        chk("arst_ocupado", 128'(ocupado), 128'd0);
        chk("arst_rodada", 128'(rodada), 128'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_pronta", 128'(entrada_pronta), 128'd1);
        roda(0);

`ifdef CONTA_BLOCOS_EN
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("cnt_rst", 128'(blocos_cifrados), 128'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) roda(i);
        chk("cnt_3", 128'(blocos_cifrados), 128'd3);
        force dut.r_blocos = 16'hffff;
        @(negedge clk);
        release dut.r_blocos;
        chk("cnt_forced", 128'(blocos_cifrados), 128'hffff);
        @(posedge clk);
        #1;
        roda(3);
        chk("cnt_wrap", 128'(blocos_cifrados), 128'd0);
`endif

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1);
    end

endmodule
